// File: rtl/pr_bus_arbiter_if.sv
// Bus bundle between the two peripheral masters, the arbiter and the timer devices.
// slave: arbiter view; master: environment view (masters plus timer read data).
interface pr_bus_arbiter_if;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned WAW = 30;

  logic           m0_req;
  logic           m1_req;
  logic           m0_we;
  logic           m1_we;
  logic [AW-1:0]  m0_addr;
  logic [AW-1:0]  m1_addr;
  logic [DW-1:0]  m0_wdata;
  logic [DW-1:0]  m1_wdata;
  logic           m0_ack;
  logic           m1_ack;
  logic [DW-1:0]  m0_rdata;
  logic [DW-1:0]  m1_rdata;
  logic           m0_err;
  logic           m1_err;
  logic [WAW-1:0] dev_addr;
  logic [DW-1:0]  dev_wd;
  logic           dev_we0;
  logic           dev_we1;
  logic [DW-1:0]  dev_rd0;
  logic [DW-1:0]  dev_rd1;
  logic           owner;

  modport slave (
    input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
    input  dev_rd0, dev_rd1,
    output m0_ack, m1_ack, m0_rdata, m1_rdata, m0_err, m1_err,
    output dev_addr, dev_wd, dev_we0, dev_we1, owner
  );

  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
    output dev_rd0, dev_rd1,
    input  m0_ack, m1_ack, m0_rdata, m1_rdata, m0_err, m1_err,
    input  dev_addr, dev_wd, dev_we0, dev_we1, owner
  );
endinterface

// File: rtl/pr_bus_arbiter.sv
// Two-master arbiter/bridge onto the timer 0/1 device bus with window decode and registered response.
// Define PR_ARB_FIXED_PRIO_EN to make m0 win every tie instead of round-robin.
module pr_bus_arbiter #(
  parameter logic [31:0] TC0_BASE  = 32'h0000_7F00,
  parameter logic [31:0] TC1_BASE  = 32'h0000_7F10,
  parameter int unsigned WIN_BYTES = 12
) (
  input  logic             clk,
  input  logic             reset,
  pr_bus_arbiter_if.slave  bus
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wd_q, wd_d;
  logic          ack0_q, ack0_d, ack1_q, ack1_d;
  logic          err0_q, err0_d, err1_q, err1_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic          sel0_c, sel1_c, hit_c, win_c;
  logic          we0_c, we1_c;
  logic [DW-1:0] resp_data_c;

  // Window decode on the latched byte address; only word-aligned hits count.
  assign sel0_c = (addr_q >= TC0_BASE) && (addr_q < (TC0_BASE + AW'(WIN_BYTES)))
                  && (addr_q[1:0] == 2'b00);
  assign sel1_c = (addr_q >= TC1_BASE) && (addr_q < (TC1_BASE + AW'(WIN_BYTES)))
                  && (addr_q[1:0] == 2'b00);
  assign hit_c  = sel0_c | sel1_c;

  // Read data returned to the owner: zero for writes and decode errors.
  always_comb begin
    resp_data_c = '0;
    if (!we_q && sel0_c) begin
      resp_data_c = bus.dev_rd0;
    end else if (!we_q && sel1_c) begin
      resp_data_c = bus.dev_rd1;
    end
  end

  // Grant selection for the IDLE cycle.
`ifdef PR_ARB_FIXED_PRIO_EN
  assign win_c = ~bus.m0_req;
`else
  assign win_c = (bus.m0_req && bus.m1_req) ? ~owner_q : bus.m1_req;
`endif

  // Next-state and output decode.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wd_d     = wd_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    err0_d   = 1'b0;
    err1_d   = 1'b0;
    rdata0_d = '0;
    rdata1_d = '0;
    we0_c    = 1'b0;
    we1_c    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          owner_d = win_c;
          we_d    = win_c ? bus.m1_we    : bus.m0_we;
          addr_d  = win_c ? bus.m1_addr  : bus.m0_addr;
          wd_d    = win_c ? bus.m1_wdata : bus.m0_wdata;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        we0_c = we_q & sel0_c;
        we1_c = we_q & sel1_c;
        if (owner_q) begin
          ack1_d   = 1'b1;
          err1_d   = ~hit_c;
          rdata1_d = resp_data_c;
        end else begin
          ack0_d   = 1'b1;
          err0_d   = ~hit_c;
          rdata0_d = resp_data_c;
        end
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and response registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      owner_q  <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wd_q     <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wd_q     <= wd_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Strobes decode straight from state so an async reset drops them at once.
  assign bus.dev_we0  = we0_c;
  assign bus.dev_we1  = we1_c;
  assign bus.dev_addr = addr_q[AW-1:2];
  assign bus.dev_wd   = wd_q;
  assign bus.owner    = owner_q;
  assign bus.m0_ack   = ack0_q;
  assign bus.m1_ack   = ack1_q;
  assign bus.m0_err   = err0_q;
  assign bus.m1_err   = err1_q;
  assign bus.m0_rdata = rdata0_q;
  assign bus.m1_rdata = rdata1_q;

endmodule

// File: tb/tb_pr_bus_arbiter.sv
// Self-checking bench for pr_bus_arbiter: transaction-level model compared every cycle,
// directed literal checks, then randomized traffic with occasional reset pulses.
module tb_pr_bus_arbiter;

  localparam logic [31:0] TC0 = 32'h0000_7F00;
  localparam logic [31:0] TC1 = 32'h0000_7F10;
  localparam int unsigned WIN = 12;

  logic clk = 1'b0;
  logic reset = 1'b0;

  pr_bus_arbiter_if bus();

  pr_bus_arbiter #(.TC0_BASE(TC0), .TC1_BASE(TC1), .WIN_BYTES(WIN)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit in_win(input logic [31:0] a, input logic [31:0] base);
    return (a >= base) && ((a - base) < WIN) && ((a % 4) == 0);
  endfunction

  // Model: one transaction record plus how many cycles have passed since its grant.
  int          since_grant;   // 0 = no transaction, 1 = strobe cycle, 2 = response cycle
  bit          m_own;
  bit          t_we;
  logic [31:0] t_addr, t_wd, exp_rd;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      since_grant <= 0;
      m_own       <= 1'b1;
      t_we        <= 1'b0;
      t_addr      <= '0;
      t_wd        <= '0;
      exp_rd      <= '0;
    end else if (since_grant == 0) begin
      if (bus.m0_req || bus.m1_req) begin
        bit w;
`ifdef PR_ARB_FIXED_PRIO_EN
        w = !bus.m0_req;
`else
        w = (bus.m0_req && bus.m1_req) ? !m_own : bus.m1_req;
`endif
        m_own       <= w;
        t_we        <= w ? bus.m1_we : bus.m0_we;
        t_addr      <= w ? bus.m1_addr : bus.m0_addr;
        t_wd        <= w ? bus.m1_wdata : bus.m0_wdata;
        since_grant <= 1;
      end
    end else if (since_grant == 1) begin
      if (t_we)                   exp_rd <= '0;
      else if (in_win(t_addr, TC0)) exp_rd <= bus.dev_rd0;
      else if (in_win(t_addr, TC1)) exp_rd <= bus.dev_rd1;
      else                        exp_rd <= '0;
      since_grant <= 2;
    end else begin
      since_grant <= 0;
    end
  end

  bit cmp_en = 1'b0;
  bit ack_seen [2];

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    bit h0, h1, acc, rsp, r0, r1;
    if (bus.m0_ack) ack_seen[0] = 1'b1;
    if (bus.m1_ack) ack_seen[1] = 1'b1;
    if (cmp_en) begin
      h0  = in_win(t_addr, TC0);
      h1  = in_win(t_addr, TC1);
      acc = (since_grant == 1);
      rsp = (since_grant == 2);
      r0  = rsp && !m_own;
      r1  = rsp && m_own;
      chk("dev_we0",  64'(bus.dev_we0),  64'(acc && t_we && h0));
      chk("dev_we1",  64'(bus.dev_we1),  64'(acc && t_we && h1));
      chk("dev_addr", 64'(bus.dev_addr), 64'(t_addr >> 2));
      chk("dev_wd",   64'(bus.dev_wd),   64'(t_wd));
      chk("owner",    64'(bus.owner),    64'(m_own));
      chk("m0_ack",   64'(bus.m0_ack),   64'(r0));
      chk("m1_ack",   64'(bus.m1_ack),   64'(r1));
      chk("m0_err",   64'(bus.m0_err),   64'(r0 && !(h0 || h1)));
      chk("m1_err",   64'(bus.m1_err),   64'(r1 && !(h0 || h1)));
      chk("m0_rdata", 64'(bus.m0_rdata), 64'(r0 ? exp_rd : 32'h0));
      chk("m1_rdata", 64'(bus.m1_rdata), 64'(r1 ? exp_rd : 32'h0));
    end
  end

  task automatic drive(input int m, input bit r, input bit we, input logic [31:0] a,
                       input logic [31:0] wd);
    if (m == 0) begin
      bus.m0_req = r; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = wd;
    end else begin
      bus.m1_req = r; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = wd;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0, 1, 2: return TC0 + 32'(4 * $urandom_range(0, 2));
      3, 4, 5: return TC1 + 32'(4 * $urandom_range(0, 2));
      6:       return 32'h0000_7F0C;
      7:       return 32'h0000_7F1C;
      8:       return TC0 + 32'($urandom_range(1, 3));
      default: return $urandom;
    endcase
  endfunction

  // One isolated transaction; samples the strobe cycle and the response cycle.
  task automatic run_txn(input int m, input bit we, input logic [31:0] a, input logic [31:0] wd,
                         output logic s0, output logic s1, output logic [29:0] da,
                         output logic [31:0] dw, output logic ack, output logic err,
                         output logic [31:0] rd);
    @(posedge clk); #1;
    drive(m, 1'b1, we, a, wd);
    @(posedge clk);
    @(negedge clk);
    s0 = bus.dev_we0; s1 = bus.dev_we1; da = bus.dev_addr; dw = bus.dev_wd;
    @(negedge clk);
    ack = (m == 0) ? bus.m0_ack : bus.m1_ack;
    err = (m == 0) ? bus.m0_err : bus.m1_err;
    rd  = (m == 0) ? bus.m0_rdata : bus.m1_rdata;
    @(posedge clk); #1;
    drive(m, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    logic s0, s1, ack, err;
    logic [29:0] da;
    logic [31:0] dw, rd;
    int exp_order [4];

    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    bus.dev_rd0 = 32'hDEAD_0000;
    bus.dev_rd1 = 32'h0000_1234;

    @(posedge clk);
    @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_owner",    64'(bus.owner),    64'h1);
    chk("rst_dev_addr", 64'(bus.dev_addr), 64'h0);
    chk("rst_m0_ack",   64'(bus.m0_ack),   64'h0);
    chk("rst_dev_we0",  64'(bus.dev_we0),  64'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    // m0 write to timer 0, word 1.
    run_txn(0, 1'b1, 32'h0000_7F04, 32'h0000_00A5, s0, s1, da, dw, ack, err, rd);
    chk("wr_we0",   64'(s0),  64'h1);
    chk("wr_we1",   64'(s1),  64'h0);
    chk("wr_daddr", 64'(da),  64'h1FC1);
    chk("wr_dwd",   64'(dw),  64'hA5);
    chk("wr_ack",   64'(ack), 64'h1);
    chk("wr_err",   64'(err), 64'h0);
    chk("wr_rdata", 64'(rd),  64'h0);

    // m1 read of timer 1.
    run_txn(1, 1'b0, 32'h0000_7F14, 32'h0, s0, s1, da, dw, ack, err, rd);
    chk("rd_we0",   64'(s0),  64'h0);
    chk("rd_we1",   64'(s1),  64'h0);
    chk("rd_ack",   64'(ack), 64'h1);
    chk("rd_err",   64'(err), 64'h0);
    chk("rd_rdata", 64'(rd),  64'h1234);

    // Gap between windows, then a misaligned write.
    run_txn(0, 1'b0, 32'h0000_7F0C, 32'h0, s0, s1, da, dw, ack, err, rd);
    chk("gap_ack",   64'(ack), 64'h1);
    chk("gap_err",   64'(err), 64'h1);
    chk("gap_rdata", 64'(rd),  64'h0);
    run_txn(1, 1'b1, 32'h0000_7F02, 32'hFFFF_FFFF, s0, s1, da, dw, ack, err, rd);
    chk("mis_strobe", 64'({s0, s1}), 64'h0);
    chk("mis_ack",    64'(ack),      64'h1);
    chk("mis_err",    64'(err),      64'h1);
    chk("mis_rdata",  64'(rd),       64'h0);

    // Both masters requesting continuously from reset.
`ifdef PR_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0};
`else
    exp_order = '{0, 1, 0, 1};
`endif
    @(posedge clk); #1;
    reset = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h0000_7F00, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h0000_7F10, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      int got, cyc;
      got = -1;
      cyc = 0;
      while (got < 0 && cyc < 12) begin
        @(negedge clk);
        if (bus.m0_ack) got = 0;
        else if (bus.m1_ack) got = 1;
        cyc++;
      end
      chk($sformatf("tie_grant%0d", k), 64'(got), 64'(exp_order[k]));
    end
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset pulse during the strobe cycle of an m1 write.
    repeat (2) @(posedge clk);
    #1;
    drive(1, 1'b1, 1'b1, 32'h0000_7F18, 32'h0000_55AA);
    @(posedge clk); #2;
    chk("rp_we1_pre", 64'(bus.dev_we1), 64'h1);
    reset = 1'b0;
    #1;
    chk("rp_we1",      64'(bus.dev_we1),  64'h0);
    chk("rp_owner",    64'(bus.owner),    64'h1);
    chk("rp_dev_addr", 64'(bus.dev_addr), 64'h0);
    chk("rp_dev_wd",   64'(bus.dev_wd),   64'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("rp_no_ack", 64'({bus.m0_ack, bus.m1_ack}), 64'h0);
    end

    // Randomized traffic; masters hold until ack, then retire or issue anew.
    ack_seen[0] = 1'b0;
    ack_seen[1] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      bus.dev_rd0 = $urandom;
      bus.dev_rd1 = $urandom;
      if (!reset) begin
        reset = 1'b1;
      end else if ($urandom_range(0, 599) == 0) begin
        reset = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        ack_seen[0] = 1'b0;
        ack_seen[1] = 1'b0;
      end else begin
        for (int m = 0; m < 2; m++) begin
          bit cur;
          cur = (m == 0) ? bus.m0_req : bus.m1_req;
          if (ack_seen[m]) begin
            ack_seen[m] = 1'b0;
            if ($urandom_range(0, 1) == 1)
              drive(m, 1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
            else
              drive(m, 1'b0, 1'b0, 32'h0, 32'h0);
          end else if (!cur && $urandom_range(0, 2) == 0) begin
            drive(m, 1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
          end
        end
      end
    end

    @(posedge clk); #1;
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
